// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S MEMS microphone receiver.
package i2s_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned SLOT_W_DEF = 32;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_t;

  typedef logic [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/clock_edge_detect.sv
// Two-flop edge detector with registered one-cycle rise/fall pulses.
module clock_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic cur_q, last_q;
  logic rise_q, fall_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cur_q  <= 1'b0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cur_q  <= d_i;
      last_q <= cur_q;
      rise_q <= cur_q & ~last_q;
      fall_q <= ~cur_q & last_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2s_mic_rx.sv
// Stereo I2S master receiver (Philips timing) for a MEMS microphone pair.
// Define I2S_SD_SYNC_EN to pass sd through a 2-flop synchroniser (needs CLK_DIV >= 3).
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned SLOT_W  = SLOT_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              sck,
  output logic              ws,
  input  logic              sd,
  output logic [DATA_W-1:0] data_left,
  output logic [DATA_W-1:0] data_right,
  output logic              frame_valid,
  output logic              ws_rise,
  output logic              ws_fall
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(2 * SLOT_W);

  logic [DivW-1:0]   div_q, div_d;
  logic              sck_q, sck_d;
  logic [BitW-1:0]   bit_q, bit_d;
  ch_t               ch_q, ch_d;
  logic [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [DATA_W-1:0] data_l_q, data_l_d, data_r_q, data_r_d;
  logic              frame_valid_q;
  logic              tc, rise_stb, fall_stb;
  logic [BitW-1:0]   slot_bit;
  logic              data_bit, load_left, load_right;
  logic              sd_s;

`ifdef I2S_SD_SYNC_EN
  logic [1:0] sd_sync_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sd_sync_q <= 2'b00;
    end else begin
      sd_sync_q <= {sd_sync_q[0], sd};
    end
  end

  assign sd_s = sd_sync_q[1];
`else
  assign sd_s = sd;
`endif

  always_comb begin
    tc       = (div_q == DivW'(CLK_DIV - 1));
    rise_stb = tc & ~sck_q;
    fall_stb = tc & sck_q;
    div_d    = tc ? '0 : div_q + DivW'(1);
    sck_d    = tc ? ~sck_q : sck_q;

    bit_d = bit_q;
    if (fall_stb) begin
      bit_d = (bit_q == BitW'(2 * SLOT_W - 1)) ? '0 : bit_q + BitW'(1);
    end
    ch_d = (bit_d >= BitW'(SLOT_W)) ? CH_RIGHT : CH_LEFT;

    // Slot cycle 0 follows the ws change and carries no data.
    slot_bit = (ch_q == CH_RIGHT) ? bit_q - BitW'(SLOT_W) : bit_q;
    data_bit = (slot_bit != '0) && (slot_bit <= BitW'(DATA_W));

    sh_l_d = sh_l_q;
    sh_r_d = sh_r_q;
    if (rise_stb && data_bit) begin
      if (ch_q == CH_LEFT) begin
        sh_l_d = {sh_l_q[DATA_W-2:0], sd_s};
      end else begin
        sh_r_d = {sh_r_q[DATA_W-2:0], sd_s};
      end
    end

    load_left  = (ch_q == CH_LEFT) && (ch_d == CH_RIGHT);
    load_right = (ch_q == CH_RIGHT) && (ch_d == CH_LEFT);
    data_l_d   = load_left ? sh_l_q : data_l_q;
    data_r_d   = load_right ? sh_r_q : data_r_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_q         <= '0;
      sck_q         <= 1'b0;
      bit_q         <= '0;
      ch_q          <= CH_LEFT;
      sh_l_q        <= '0;
      sh_r_q        <= '0;
      data_l_q      <= '0;
      data_r_q      <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      sck_q         <= sck_d;
      bit_q         <= bit_d;
      ch_q          <= ch_d;
      sh_l_q        <= sh_l_d;
      sh_r_q        <= sh_r_d;
      data_l_q      <= data_l_d;
      data_r_q      <= data_r_d;
      frame_valid_q <= load_right;
    end
  end

  assign sck         = sck_q;
  assign ws          = ch_q;
  assign data_left   = data_l_q;
  assign data_right  = data_r_q;
  assign frame_valid = frame_valid_q;

  clock_edge_detect u_ws_edge (
    .CLK    (CLK),
    .RESET  (RESET),
    .d_i    (ch_q),
    .rise_o (ws_rise),
    .fall_o (ws_fall)
  );

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Scoreboard bench for i2s_mic_rx: randomized frames driven as an I2S bit stream.
module tb_i2s_mic_rx;

`ifdef I2S_SD_SYNC_EN
  localparam int CLK_DIV = 4;
`else
  localparam int CLK_DIV = 2;
`endif
  localparam int DATA_W = 16;
  localparam int SLOT_W = 32;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              sd = 1'b0;
  logic              sck, ws, frame_valid, ws_rise, ws_fall;
  logic [DATA_W-1:0] data_left, data_right;

  always #5 CLK = ~CLK;

  i2s_mic_rx #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W),
    .SLOT_W  (SLOT_W)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .sck         (sck),
    .ws          (ws),
    .sd          (sd),
    .data_left   (data_left),
    .data_right  (data_right),
    .frame_valid (frame_valid),
    .ws_rise     (ws_rise),
    .ws_fall     (ws_fall)
  );

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_left_q[$];
  logic [DATA_W-1:0] exp_right_q[$];
  bit first_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h with nothing expected at %0t", name, act, $time);
  endtask

  // Frame = 2*SLOT_W bit periods; slot cycles 1..DATA_W carry the word MSB first.
  task automatic drive_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                             input bit junk_ones, input int stop_bit);
    logic [DATA_W-1:0] w;
    int k;
    logic b;
    if (stop_bit >= SLOT_W) exp_left_q.push_back(l);
    if (stop_bit >= 2 * SLOT_W - 1) exp_right_q.push_back(r);
    for (int i = 0; i <= stop_bit; i++) begin
      w = (i < SLOT_W) ? l : r;
      k = i % SLOT_W;
      if (k >= 1 && k <= DATA_W) b = w[DATA_W-k];
      else b = junk_ones ? 1'b1 : 1'($urandom_range(0, 1));
      if (first_bit) first_bit = 0;
      else @(negedge sck);
      #1;
      sd = b;
    end
  endtask

  // Monitor
  int cyc = 0, rel_cyc = 0, last_rise = -1, last_tog = -1, rise_cyc = 0, fall_cyc = 0;
  bit rise_pend = 0, fall_pend = 0;
  logic p_sck = 0, p_ws = 0;
  int n_fv = 0, n_rise_pulse = 0, n_fall_pulse = 0;

  always @(posedge CLK) begin
    #1;
    cyc++;
    if (!RESET) begin
      rel_cyc   = cyc;
      p_sck     = 0;
      p_ws      = 0;
      last_rise = -1;
      last_tog  = -1;
      rise_pend = 0;
      fall_pend = 0;
    end else begin
      if (sck && !p_sck) begin
        if (last_rise < 0) check("first_sck_rise", cyc - rel_cyc, CLK_DIV);
        else check("sck_period", cyc - last_rise, 2 * CLK_DIV);
        last_rise = cyc;
      end
      if (!sck && p_sck) check("sck_high_time", cyc - last_rise, CLK_DIV);
      if (ws != p_ws) begin
        check("ws_with_sck_fall", {p_sck, sck}, 2'b10);
        if (last_tog < 0) check("first_ws_toggle", cyc - rel_cyc, 2 * CLK_DIV * SLOT_W);
        else check("ws_half_period", cyc - last_tog, 2 * CLK_DIV * SLOT_W);
        last_tog = cyc;
        if (ws) begin
          rise_pend = 1;
          rise_cyc  = cyc;
          if (exp_left_q.size() == 0) flag("data_left_unexpected", data_left);
          else check("data_left", data_left, exp_left_q.pop_front());
        end else begin
          fall_pend = 1;
          fall_cyc  = cyc;
        end
      end
      if (frame_valid) begin
        n_fv++;
        check("frame_valid_at_ws_fall", {p_ws, ws}, 2'b10);
        if (exp_right_q.size() == 0) flag("data_right_unexpected", data_right);
        else check("data_right", data_right, exp_right_q.pop_front());
      end
      if (ws_rise) begin
        n_rise_pulse++;
        check("ws_rise_latency", rise_pend ? cyc - rise_cyc : -1, 2);
        rise_pend = 0;
      end else if (rise_pend && cyc - rise_cyc > 2) begin
        check("ws_rise_pulse", ws_rise, 1'b1);
        rise_pend = 0;
      end
      if (ws_fall) begin
        n_fall_pulse++;
        check("ws_fall_latency", fall_pend ? cyc - fall_cyc : -1, 2);
        fall_pend = 0;
      end else if (fall_pend && cyc - fall_cyc > 2) begin
        check("ws_fall_pulse", ws_fall, 1'b1);
        fall_pend = 0;
      end
      p_sck = sck;
      p_ws  = ws;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_sck"}, sck, 0);
    check({tag, "_ws"}, ws, 0);
    check({tag, "_data_left"}, data_left, 0);
    check({tag, "_data_right"}, data_right, 0);
    check({tag, "_frame_valid"}, frame_valid, 0);
    check({tag, "_ws_rise"}, ws_rise, 0);
    check({tag, "_ws_fall"}, ws_fall, 0);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (4) @(posedge CLK);
    #1;
    check_zero("reset");
    @(negedge CLK);
    RESET     = 1'b1;
    first_bit = 1;
    drive_frame(16'hA5C3, 16'h3C5A, 0, 2 * SLOT_W - 1);
    drive_frame(16'h0001, 16'($urandom), 1, 2 * SLOT_W - 1);
    for (int f = 0; f < 3; f++) begin
      drive_frame(16'($urandom), 16'($urandom), 0, 2 * SLOT_W - 1);
    end
    // Interrupt the next frame in the middle of its right slot.
    drive_frame(16'($urandom) | 16'h0100, 16'($urandom), 0, SLOT_W + DATA_W);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (5) @(negedge CLK);
    RESET     = 1'b1;
    first_bit = 1;
    drive_frame(16'h1234, 16'h8001, 0, 2 * SLOT_W - 1);
    drive_frame(16'($urandom), 16'($urandom), 0, 2 * SLOT_W - 1);
    @(negedge sck);
    repeat (5) @(posedge CLK);
    #2;
    check("frame_valid_count", n_fv, 7);
    check("ws_rise_pulse_count", n_rise_pulse, 8);
    check("ws_fall_pulse_count", n_fall_pulse, 7);
    check("left_queue_drained", exp_left_q.size(), 0);
    check("right_queue_drained", exp_right_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_mic_rx.md
# i2s_mic_rx

Stereo I2S master receiver for a digital MEMS microphone pair. It generates the bit clock `sck` and word select `ws` from the system clock, then deserialises the microphone data line into 16-bit left and right samples. It also produces one-cycle pulses on each `ws` edge, which the Avalon register/interrupt wrapper uses as its sample-ready interrupt source.

## Interface
Parameters:
- `CLK_DIV`, default 4: number of `CLK` cycles per `sck` half-period. Legal range ≥2; ≥3 when `I2S_SD_SYNC_EN` is defined.
- `DATA_W`, default 16: captured sample width.
- `SLOT_W`, default 32: `sck` cycles per `ws` half (channel slot). Must be ≥ `DATA_W`+1.

Ports:
- `CLK` in 1: system clock. One clock only.
- `RESET` in 1: reset, asynchronous, active-low.
- `sck` out 1: I2S bit clock, registered.
- `ws` out 1: word select, registered; 0 = left, 1 = right.
- `sd` in 1: serial data from the microphones.
- `data_left` out DATA_W: last complete left sample.
- `data_right` out DATA_W: last complete right sample.
- `frame_valid` out 1: one-cycle pulse when `data_right` updates (stereo frame complete).
- `ws_rise` out 1: one-cycle pulse per `ws` rising edge.
- `ws_fall` out 1: one-cycle pulse per `ws` falling edge.

## Operation
- Divider counter 0..CLK_DIV-1. At terminal count, `sck` toggles and the counter wraps to 0. This gives an `sck` period of 2·CLK_DIV `CLK` cycles.
- Internal strobes:
  - `rise_stb`: the cycle in which `sck` goes 0→1.
  - `fall_stb`: the cycle in which `sck` goes 1→0.
- Bit counter 0..2·SLOT_W-1 advances on each `fall_stb` and wraps.
- `ws` = bit counter ≥ SLOT_W. `ws` therefore changes only together with an `sck` falling edge.
- Philips timing: within each slot, `sck` cycle 0 (the first after the `ws` change) is ignored. Cycles 1..DATA_W carry data MSB first. The remaining cycles are ignored.
- On `rise_stb` in slot cycles 1..DATA_W, `sd` is shifted into that channel's shift register from the LSB side.
- `data_left` loads from the left shift register in the cycle `ws` goes 0→1.
- `data_right` loads from the right shift register in the cycle `ws` goes 1→0. `frame_valid` pulses in that same cycle.
- `clock_edge_detect` on `ws`:
  - Registers `cur` ← `ws`, then `last` ← `cur`.
  - `ws_rise` = `cur & ~last`; `ws_fall` = `~cur & last`.
- Width rule: the shift registers are DATA_W wide. No sign extension and no truncation.

## Timing
- Reset (asynchronous assert, released synchronously to `CLK` by the integrator): all of the following are 0:
  - `sck`, `ws`
  - counters and shift registers
  - `data_left`, `data_right`
  - `frame_valid`, `ws_rise`, `ws_fall`
  - detector `cur` and `last`
- No spurious edge pulse after reset.
- First `sck` rise occurs CLK_DIV cycles after reset release. The first slot is left.
- The first `data_left` is valid after SLOT_W `sck` periods. The first `frame_valid` occurs after 2·SLOT_W `sck` periods.
- Edge pulse latency: if `ws` toggles at `CLK` edge t, the pulse is high from edge t+2 to t+3, for exactly one cycle.
- Reset asserted mid-slot: the partial sample is discarded, outputs clear immediately, and the frame restarts with the left slot.
- `sd` is sampled in the `rise_stb` cycle. Without the synchroniser, `sd` must be stable for the `CLK` edge that produces `rise_stb`.

## Configuration
- `I2S_SD_SYNC_EN` defined: `sd` passes through a 2-flop synchroniser before sampling. This adds 2 `CLK` cycles of sample latency, and `CLK_DIV` ≥3 is required.
- `I2S_SD_SYNC_EN` not defined: `sd` is sampled directly.
- Output data timing relative to `ws` is identical in both cases.

## Structure
- Package `i2s_pkg`:
  - `DATA_W_DEF`, `SLOT_W_DEF`
  - `typedef enum logic {CH_LEFT, CH_RIGHT} ch_t`
  - `typedef logic [DATA_W_DEF-1:0] sample_t`
- One sub-module, `clock_edge_detect`, containing the two-flop edge detector with rise/fall outputs and asynchronous active-low reset.
- The divider, bit counter and shift/capture logic stay in the top module.

## Test plan
All scenarios use CLK_DIV=2, SLOT_W=32, DATA_W=16 unless stated otherwise.

- **Clock generation:** after reset release, `sck` period = 4 `CLK` cycles, 50% duty. `ws` toggles every 128 `CLK` cycles, each time coincident with an `sck` fall.
- **Capture:** drive left 0xA5C3 then right 0x3C5A (Philips, MSB in slot cycle 1).
  - `data_left`=0xA5C3 at `ws`↑.
  - `data_right`=0x3C5A at `ws`↓.
  - One `frame_valid` pulse per frame.
- **Ignored bits:** drive `sd`=1 in slot cycle 0 and in cycles 17..31, with data bits 0x0001. Captured value = 0x0001.
- **Edge pulses:** over 3 frames, exactly 3 `ws_rise` and 3 `ws_fall`, each 1 cycle wide, 2 cycles after the `ws` toggle. No pulse after reset.
- **Reset mid-operation:** assert `RESET` in the middle of the right slot.
  - All outputs are 0 immediately.
  - After release, the next frame 0x1234/0x8001 is captured correctly.
- **Synchroniser (`I2S_SD_SYNC_EN`, CLK_DIV=4):** the capture test passes with the same values. `sd` changes within 2 cycles before `rise_stb` are taken on the next bit.
